// File: rtl/reset_monitor_pkg.sv
// -----------------------------------------------------------------------------
// reset_monitor_pkg
// Definitions shared by the RESET pulse generator and the reset_monitor
// receiver: monitor state encoding, the default counter width, and the
// nominal RESET pulse timing. Both ends take their timing from here.
// -----------------------------------------------------------------------------
package reset_monitor_pkg;

    // Default width of duration counters and measured/expected times.
    localparam int CNT_W_DEFAULT = 16;

    // Nominal RESET pulse timing, in clk cycles, emitted by the generator.
    localparam int RST_HIGH_CYCLES   = 2;
    localparam int RST_LOW_CYCLES    = 98;
    localparam int RST_PERIOD_CYCLES = RST_HIGH_CYCLES + RST_LOW_CYCLES;

    // Monitor state encoding; the unused code 2'd3 is recovered to S_WAIT.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/reset_monitor_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a SYNC_STAGES-deep
// flop chain and reports its synchronized value plus rise/fall strobes.
// Edges are only reported once both the synchronized value and its delayed
// copy hold samples taken after reset release, so a level already present at
// reset release is never mistaken for an edge.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   din    in   asynchronous input level
//   s      out  synchronized level
//   rise   out  one-cycle strobe, s went 0->1
//   fall   out  one-cycle strobe, s went 1->0
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    // Tracks how far post-reset samples have travelled down the chain; the
    // top bit means both s and s_d carry real samples.
    logic [SYNC_STAGES:0]   vld_r;
    logic                   edge_ok_s;

    // Synchronizer chain, one-cycle delayed copy, and post-reset fill tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            s_d_r  <= 1'b0;
            vld_r  <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            s_d_r  <= sync_r[SYNC_STAGES-1];
            vld_r  <= {vld_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s         = sync_r[SYNC_STAGES-1];
    assign edge_ok_s = vld_r[SYNC_STAGES];
    assign rise      = edge_ok_s &  s & ~s_d_r;
    assign fall      = edge_ok_s & ~s &  s_d_r;

endmodule

// File: rtl/reset_monitor.sv
// -----------------------------------------------------------------------------
// reset_monitor
// Receive-side monitor for the periodic RESET pulse train. Measures every high
// and low phase in clk cycles, reports each completed period with a one-cycle
// meas_valid strobe, compares it with the expected timing, and flags a line
// stuck high or low (phase counter saturated).
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   pulse_in      in   monitored RESET line, asynchronous to clk
//   exp_high      in   expected high duration (0 disables the check)
//   exp_low       in   expected low duration (0 disables the check)
//   clear_flags   in   one-cycle pulse clearing the sticky flags
//   high_time     out  last measured high duration
//   low_time      out  last measured low duration
//   meas_valid    out  one-cycle strobe, new high_time/low_time pair
//   period_count  out  completed periods, wraps
//   mismatch      out  sticky, a period differed from expected timing
//   stuck_high    out  sticky, a high phase saturated the counter
//   stuck_low     out  sticky, a low phase saturated the counter
// -----------------------------------------------------------------------------
module reset_monitor
    import reset_monitor_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] exp_high,
    input  logic [CNT_W-1:0] exp_low,
    input  logic             clear_flags,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_count,
    output logic             mismatch,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A measured duration is wrong only when an expectation is programmed.
    function automatic logic time_mismatch(
        input logic [CNT_W-1:0] meas,
        input logic [CNT_W-1:0] expv
    );
        return (expv != {CNT_W{1'b0}}) && (meas != expv);
    endfunction

    mon_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hi_lat_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             s_s;
    logic             rise_s;
    logic             fall_s;
    logic             hi_sat_set_s;
    logic             lo_sat_set_s;
    logic             mis_set_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pulse_in),
        .s     (s_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Saturating increment: the counter holds at all-ones once reached.
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);

    // Judged on the meas_valid cycle against the exp values present then.
    assign mis_set_s = meas_valid &&
                       (time_mismatch(high_time, exp_high) ||
                        time_mismatch(low_time, exp_low));

    // Stuck conditions: the running phase count is (or stays) saturated
    always_comb begin
        hi_sat_set_s = 1'b0;
        lo_sat_set_s = 1'b0;
        case (state_r)
            S_HIGH: begin
                if (s_s && !fall_s) begin
                    hi_sat_set_s = (cnt_inc_s == CNT_MAX);
                end else begin
                    hi_sat_set_s = 1'b0;
                end
            end
            S_LOW: begin
                if (!s_s && !rise_s) begin
                    lo_sat_set_s = (cnt_inc_s == CNT_MAX);
                end else begin
                    lo_sat_set_s = 1'b0;
                end
            end
            default: begin
                hi_sat_set_s = 1'b0;
                lo_sat_set_s = 1'b0;
            end
        endcase
    end

    // Phase-measurement FSM with its counters and report registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_WAIT;
            cnt_r        <= '0;
            hi_lat_r     <= '0;
            high_time    <= '0;
            low_time     <= '0;
            meas_valid   <= 1'b0;
            period_count <= '0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                S_WAIT: begin
                    // Whatever level was present at reset release is
                    // ignored; measuring starts at the first real rise.
                    if (rise_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= S_HIGH;
                    end else begin
                        cnt_r   <= '0;
                    end
                end
                S_HIGH: begin
                    if (fall_s) begin
                        hi_lat_r <= cnt_r;
                        cnt_r    <= CNT_ONE;
                        state_r  <= S_LOW;
                    end else begin
                        cnt_r    <= cnt_inc_s;
                    end
                end
                S_LOW: begin
                    if (rise_s) begin
                        high_time    <= hi_lat_r;
                        low_time     <= cnt_r;
                        meas_valid   <= 1'b1;
                        period_count <= period_count + CNT_ONE;
                        cnt_r        <= CNT_ONE;
                        state_r      <= S_HIGH;
                    end else begin
                        cnt_r        <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= S_WAIT;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Sticky flags: a set event in the clear cycle wins
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch   <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            mismatch   <= (mismatch   & ~clear_flags) | mis_set_s;
            stuck_high <= (stuck_high & ~clear_flags) | hi_sat_set_s;
            stuck_low  <= (stuck_low  & ~clear_flags) | lo_sat_set_s;
        end
    end

endmodule

// File: tb/tb_reset_monitor.sv
// -----------------------------------------------------------------------------
// tb_reset_monitor
// Drives pulse trains into reset_monitor and compares every output on every
// cycle against a run-length model of the line. The model looks only at the
// sequence of pulse_in samples taken after reset release: it closes a run on
// each level change, reports a period on each rise that follows a complete
// high+low pair, and flags a run reaching the counter ceiling. Its results
// appear at the outputs SYNC_STAGES cycles after the sample that caused them.
// Counters are 12 bits here so saturation and wrap fit in a short run.
// -----------------------------------------------------------------------------
module tb_reset_monitor;
    import reset_monitor_pkg::*;

    localparam int CW   = 12;
    localparam int NS   = 2;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          pulse_in;
    logic [CW-1:0] exp_high;
    logic [CW-1:0] exp_low;
    logic          clear_flags;
    logic [CW-1:0] high_time;
    logic [CW-1:0] low_time;
    logic          meas_valid;
    logic [CW-1:0] period_count;
    logic          mismatch;
    logic          stuck_high;
    logic          stuck_low;

    reset_monitor #(.CNT_W(CW), .SYNC_STAGES(NS)) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .exp_high     (exp_high),
        .exp_low      (exp_low),
        .clear_flags  (clear_flags),
        .high_time    (high_time),
        .low_time     (low_time),
        .meas_valid   (meas_valid),
        .period_count (period_count),
        .mismatch     (mismatch),
        .stuck_high   (stuck_high),
        .stuck_low    (stuck_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic          sh;
        logic          sl;
        logic [CW-1:0] hi;
        logic [CW-1:0] lo;
    } ev_t;

    ev_t           pipe [NS];
    ev_t           e_out;
    ev_t           e_new;
    logic          m_valid, m_mis, m_sh, m_sl, mis_set;
    logic [CW-1:0] m_hi, m_lo, m_cnt;
    int            run, hi_len;
    bit            have_prev, started;
    logic          prev, x;

    function automatic logic [CW-1:0] sat(input int v);
        return (v > MAXV) ? CW'(MAXV) : CW'(v);
    endfunction

    initial begin
        m_valid = 1'b0; m_mis = 1'b0; m_sh = 1'b0; m_sl = 1'b0;
        m_hi = '0; m_lo = '0; m_cnt = '0;
        run = 0; hi_len = 0; have_prev = 0; started = 0; prev = 1'b0;
        for (int i = 0; i < NS; i++) pipe[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b0; m_mis = 1'b0; m_sh = 1'b0; m_sl = 1'b0;
                m_hi = '0; m_lo = '0; m_cnt = '0;
                run = 0; hi_len = 0; have_prev = 0; started = 0;
                for (int i = 0; i < NS; i++) pipe[i] = '0;
            end else begin
                // outputs: apply the event from NS samples ago
                e_out   = pipe[NS-1];
                mis_set = m_valid && ((exp_high != '0 && m_hi != exp_high) ||
                                      (exp_low  != '0 && m_lo != exp_low));
                m_mis   = (m_mis && !clear_flags) || mis_set;
                m_sh    = (m_sh  && !clear_flags) || e_out.sh;
                m_sl    = (m_sl  && !clear_flags) || e_out.sl;
                m_valid = e_out.v;
                if (e_out.v) begin
                    m_hi  = e_out.hi;
                    m_lo  = e_out.lo;
                    m_cnt = m_cnt + 1'b1;
                end
                // input side: run-length analysis of this sample
                e_new = '0;
                x = pulse_in;
                if (!have_prev) begin
                    have_prev = 1; prev = x; run = 1;
                end else if (x != prev) begin
                    if (x) begin
                        if (started) begin
                            e_new.v  = 1'b1;
                            e_new.hi = sat(hi_len);
                            e_new.lo = sat(run);
                        end
                        started = 1;
                    end else if (started) begin
                        hi_len = run;
                    end
                    prev = x; run = 1;
                end else if (run < 1000000) begin
                    run = run + 1;
                end
                if (started && run >= MAXV) begin
                    if (x) e_new.sh = 1'b1;
                    else   e_new.sl = 1'b1;
                end
                for (int i = NS - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = e_new;
            end
        end
    end

    // ---------------- checking ----------------
    int            n_chk = 0;
    int            n_fail = 0;
    int            rep_total = 0;
    int            base;
    logic [CW-1:0] rep_hi = '0;
    logic [CW-1:0] rep_lo = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic compare_all();
        chk("meas_valid",   32'(meas_valid),   32'(m_valid));
        chk("high_time",    32'(high_time),    32'(m_hi));
        chk("low_time",     32'(low_time),     32'(m_lo));
        chk("period_count", 32'(period_count), 32'(m_cnt));
        chk("mismatch",     32'(mismatch),     32'(m_mis));
        chk("stuck_high",   32'(stuck_high),   32'(m_sh));
        chk("stuck_low",    32'(stuck_low),    32'(m_sl));
        if (meas_valid) begin
            rep_total++;
            rep_hi = high_time;
            rep_lo = low_time;
        end
    endtask

    // One cycle: check the outputs, then drive the next inputs.
    task automatic step(input logic pin, input logic clr);
        @(negedge clk);
        compare_all();
        pulse_in    = pin;
        clear_flags = clr;
    endtask

    task automatic phase(input logic v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    task automatic rphase(input logic v, input int n);
        repeat (n) step(v, ($urandom % 20) == 0);
    endtask

    task automatic apply_reset(input logic pin, input int n);
        reset = 1'b1;
        repeat (n) step(pin, 1'b0);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; pulse_in = 1'b0; clear_flags = 1'b0;
        exp_high = '0; exp_low = '0;

        // nominal generator timing, matching expectations
        exp_high = CW'(RST_HIGH_CYCLES);
        exp_low  = CW'(RST_LOW_CYCLES);
        apply_reset(1'b0, 3);
        chk("rst_count", 32'(period_count), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        base = rep_total;
        repeat (3) begin
            phase(1'b1, RST_HIGH_CYCLES);
            phase(1'b0, RST_LOW_CYCLES);
        end
        phase(1'b1, 2); phase(1'b0, 10);
        chk("A_reports", 32'(rep_total - base), 32'd3);
        chk("A_high", 32'(rep_hi), 32'd2);
        chk("A_low", 32'(rep_lo), 32'd98);
        chk("A_count", 32'(period_count), 32'd3);
        chk("A_mismatch", 32'(mismatch), 32'd0);

        // wrong expected low time, clear, re-set
        exp_low = CW'(97);
        apply_reset(1'b0, 3);
        base = rep_total;
        repeat (2) begin phase(1'b1, 2); phase(1'b0, 98); end
        phase(1'b1, 2); phase(1'b0, 10);
        chk("B_reports", 32'(rep_total - base), 32'd2);
        chk("B_mismatch_set", 32'(mismatch), 32'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("B_mismatch_clr", 32'(mismatch), 32'd0);
        phase(1'b0, 20); phase(1'b1, 2); phase(1'b0, 10);
        chk("B_mismatch_reset", 32'(mismatch), 32'd1);

        // line high at reset release: partial pulse ignored
        exp_high = '0; exp_low = '0;
        apply_reset(1'b1, 3);
        base = rep_total;
        phase(1'b1, 4); phase(1'b0, 5); phase(1'b1, 3); phase(1'b0, 5);
        phase(1'b1, 2); phase(1'b0, 10);
        chk("C_reports", 32'(rep_total - base), 32'd1);
        chk("C_high", 32'(rep_hi), 32'd3);
        chk("C_low", 32'(rep_lo), 32'd5);

        // stuck high, clear while still saturated, then stuck low
        apply_reset(1'b0, 3);
        phase(1'b0, 3);
        phase(1'b1, 4500); step(1'b1, 1'b1); phase(1'b1, 499);
        phase(1'b0, 10); phase(1'b1, 2); phase(1'b0, 10);
        chk("D_stuck_high", 32'(stuck_high), 32'd1);
        chk("D_sat_high", 32'(rep_hi), 32'(MAXV));
        chk("D_low10", 32'(rep_lo), 32'd10);
        chk("D_no_stuck_low", 32'(stuck_low), 32'd0);
        phase(1'b0, 5000); phase(1'b1, 2); phase(1'b0, 10);
        chk("D_stuck_low", 32'(stuck_low), 32'd1);
        chk("D_sat_low", 32'(rep_lo), 32'(MAXV));
        chk("D_high2", 32'(rep_hi), 32'd2);
        step(1'b0, 1'b1); step(1'b0, 1'b0);
        chk("D_clr_high", 32'(stuck_high), 32'd0);
        chk("D_clr_low", 32'(stuck_low), 32'd0);

        // reset in the middle of a low phase
        apply_reset(1'b0, 3);
        phase(1'b1, 3); phase(1'b0, 4); phase(1'b1, 3); phase(1'b0, 2);
        reset = 1'b1;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        chk("E_rst_count", 32'(period_count), 32'd0);
        chk("E_rst_high", 32'(high_time), 32'd0);
        chk("E_rst_low", 32'(low_time), 32'd0);
        reset = 1'b0;
        base = rep_total;
        phase(1'b0, 3); phase(1'b1, 3); phase(1'b0, 4); phase(1'b1, 3);
        phase(1'b0, 4); phase(1'b1, 1); phase(1'b0, 10);
        chk("E_reports", 32'(rep_total - base), 32'd2);
        chk("E_high", 32'(rep_hi), 32'd3);
        chk("E_low", 32'(rep_lo), 32'd4);
        chk("E_count", 32'(period_count), 32'd2);

        // 1/1 alternation through the period counter wrap
        exp_high = CW'(1); exp_low = CW'(1);
        apply_reset(1'b0, 3);
        phase(1'b0, 2);
        repeat (4098) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
        phase(1'b1, 1); phase(1'b0, 10);
        chk("F_wrap_count", 32'(period_count), 32'd2);
        chk("F_high", 32'(rep_hi), 32'd1);
        chk("F_low", 32'(rep_lo), 32'd1);
        chk("F_mismatch", 32'(mismatch), 32'd0);

        // random phases, expectations, clears and occasional resets
        apply_reset(1'b0, 2);
        for (int it = 0; it < 400; it++) begin
            if ((it % 10) == 0) begin
                exp_high = (($urandom % 3) == 0) ? CW'(0) : CW'(1 + ($urandom % 6));
                exp_low  = (($urandom % 3) == 0) ? CW'(0) : CW'(1 + ($urandom % 6));
            end
            rphase(1'b1, 1 + int'($urandom % 6));
            rphase(1'b0, 1 + int'($urandom % 6));
            if (($urandom % 60) == 0) apply_reset(1'($urandom % 2), 1 + int'($urandom % 2));
        end
        phase(1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
